// File: rtl/fpu_cvt_if.sv
// ---------------------------------------------------------------------------
// fpu_cvt_if : request/result bundle of the fpu_cvt integer/float converter.
//
// Handshake (start/done): the master raises start together with instr and
// operand; the converter takes them only while it is idle (busy=0). Exactly
// one done pulse follows each taken request, four cycles later. result, ovf
// and inv are meaningful from that done cycle on and hold until the next done.
// A start seen while busy=1 is dropped without any effect.
//
// Signals:
//   start     master -> slave  request strobe
//   instr     master -> slave  opcode (5'h13 ITOF, 5'h12 FTOI, others invalid)
//   operand   master -> slave  source value, DW bits
//   result    slave -> master  converted value, DW bits
//   busy      slave -> master  converter is in a non-idle state
//   done      slave -> master  one-cycle result-valid pulse
//   ovf       slave -> master  saturation flag
//   inv       slave -> master  illegal-opcode flag
//   dbg_state slave -> master  FSM state (0 IDLE, 1 S1, 2 S2, 3 S3)
// ---------------------------------------------------------------------------
interface fpu_cvt_if #(
   parameter int DW = 16
);
   logic          start;
   logic [4:0]    instr;
   logic [DW-1:0] operand;
   logic [DW-1:0] result;
   logic          busy;
   logic          done;
   logic          ovf;
   logic          inv;
   logic [1:0]    dbg_state;

   modport master (
      output start, instr, operand,
      input  result, busy, done, ovf, inv, dbg_state
   );

   modport slave (
      input  start, instr, operand,
      output result, busy, done, ovf, inv, dbg_state
   );
endinterface

// File: rtl/fpu_cvt.sv
// ---------------------------------------------------------------------------
// fpu_cvt : fixed-latency integer <-> float converter (ITOF / FTOI).
//
// Float format: {sign, exp[EW], mant[MW]}, bias 2^(EW-1)-1, implied leading
// one, exp==0 is zero, no inf/NaN/denormals. Integers are IW-bit two's
// complement. Every request goes IDLE -> S1 -> S2 -> S3 -> IDLE and done
// pulses in the cycle after S3, whatever the opcode or value.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fpu_cvt_if slave modport (start/instr/operand in,
//          result/busy/done/ovf/inv/dbg_state out)
//
// Optional build macro: FPU_CVT_ROUND_NEAREST_EN
//   defined   -> ITOF rounds to nearest-even (guard + sticky)
//   undefined -> ITOF truncates toward zero
// ---------------------------------------------------------------------------
module fpu_cvt #(
   parameter int EW = 8,
   parameter int MW = 7,
   parameter int IW = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   fpu_cvt_if.slave bus
);
   localparam int FW   = 1 + EW + MW;
   localparam int DW   = (FW > IW) ? FW : IW;
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam int EMAX = (1 << EW) - 1;
   localparam int LW   = $clog2(IW);
   localparam logic [4:0] OP_FTOI = 5'h12;
   localparam logic [4:0] OP_ITOF = 5'h13;

   typedef enum logic [1:0] {IDLE = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_itof, r_ftoi;
   logic [DW-1:0] r_opnd;
   logic          r_sign;
   logic [IW-1:0] r_mag;
   logic [EW-1:0] r_exp;
   logic [MW-1:0] r_mant;
   logic          r_sat, r_zero;
   logic [EW-1:0] r_fexp;
   logic [MW-1:0] r_fmant;
   logic [IW-1:0] r_imag;
   logic [DW-1:0] r_result;
   logic          r_done, r_ovf, r_inv;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = S1;
         S1:      w_state_nxt = S2;
         S2:      w_state_nxt = S3;
         S3:      w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- ITOF normalise (used in S2) ----------------
   logic [LW-1:0] w_lead;      // bit position of the leading one of r_mag
   logic [LW-1:0] w_shl;
   logic [MW:0]   w_top;       // leading one followed by MW mantissa bits
   logic [MW-1:0] w_mant_i;
   logic [31:0]   w_exp_full;  // unbounded biased exponent, checked against EMAX
   logic          w_isat;
`ifdef FPU_CVT_ROUND_NEAREST_EN
   logic [IW-1:0] w_low;       // bits below the mantissa, guard bit at the top
   logic          w_rnd, w_carry;
`endif

   always_comb begin
      w_lead = '0;
      for (int i = 0; i < IW; i++)
         if (r_mag[i]) w_lead = LW'(i);
      w_shl = LW'(IW - 1) - w_lead;
      // Shift the leading one to the top of an IW+MW+1 field; the top MW+1
      // bits are then the significand whatever the relation of MW and IW.
      w_top      = (MW+1)'(({r_mag, {(MW+1){1'b0}}} << w_shl) >> IW);
      w_exp_full = 32'(BIAS) + 32'(w_lead);
`ifdef FPU_CVT_ROUND_NEAREST_EN
      w_low = IW'({r_mag, {(MW+1){1'b0}}} << w_shl);
      w_rnd = w_low[IW-1] & ((|w_low[IW-2:0]) | w_top[0]);
      {w_carry, w_mant_i} = {1'b0, w_top[MW-1:0]} + {{MW{1'b0}}, w_rnd};
      // A mantissa carry-out leaves the fraction at zero and bumps the exponent.
      w_exp_full = w_exp_full + {31'd0, w_carry};
`else
      w_mant_i = w_top[MW-1:0];
`endif
      w_isat = (w_exp_full > 32'(EMAX));
   end

   // ---------------- FTOI align (used in S2) ----------------
   logic signed [31:0]   w_e;
   logic [IW+MW:0]       w_big;
   logic [IW-1:0]        w_imag;
   logic                 w_fsat;

   always_comb begin
      w_e    = 32'(r_exp) - 32'(BIAS);
      w_big  = {{IW{1'b0}}, 1'b1, r_mant};
      w_imag = '0;
      w_fsat = 1'b0;
      if (r_exp == '0 || w_e < 0) begin
         w_imag = '0;
      end else if (w_e >= IW - 1) begin
         // -2^(IW-1) is representable; everything else this large saturates.
         if (r_sign && w_e == IW - 1 && r_mant == '0) w_imag = {1'b1, {(IW-1){1'b0}}};
         else                                         w_fsat = 1'b1;
      end else if (w_e <= MW) begin
         w_imag = IW'(w_big >> (MW - w_e));
      end else begin
         w_imag = IW'(w_big << (w_e - MW));
      end
   end

   // ---------------- S3 pack / negate ----------------
   logic [DW-1:0] w_result;

   always_comb begin
      w_result = '0;
      if (r_itof) begin
         if (r_zero)     w_result = '0;
         else if (r_sat) w_result = DW'({r_sign, {(EW+MW){1'b1}}});
         else            w_result = DW'({r_sign, r_fexp, r_fmant});
      end else if (r_ftoi) begin
         if (r_sat)      w_result = DW'({r_sign, {(IW-1){~r_sign}}});
         else            w_result = DW'(r_sign ? -r_imag : r_imag);
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_itof   <= 1'b0;
         r_ftoi   <= 1'b0;
         r_opnd   <= '0;
         r_sign   <= 1'b0;
         r_mag    <= '0;
         r_exp    <= '0;
         r_mant   <= '0;
         r_sat    <= 1'b0;
         r_zero   <= 1'b0;
         r_fexp   <= '0;
         r_fmant  <= '0;
         r_imag   <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_inv    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_itof <= (bus.instr == OP_ITOF);
               r_ftoi <= (bus.instr == OP_FTOI);
               r_opnd <= bus.operand;
            end
            S1: begin
               if (r_itof) begin
                  r_sign <= r_opnd[IW-1];
                  r_mag  <= r_opnd[IW-1] ? -r_opnd[IW-1:0] : r_opnd[IW-1:0];
               end else begin
                  r_sign <= r_opnd[FW-1];
                  r_exp  <= r_opnd[FW-2:MW];
                  r_mant <= r_opnd[MW-1:0];
               end
            end
            S2: begin
               r_fexp  <= w_exp_full[EW-1:0];
               r_fmant <= w_mant_i;
               r_zero  <= ~w_top[MW];
               r_imag  <= w_imag;
               r_sat   <= r_itof ? w_isat : w_fsat;
            end
            S3: begin
               r_done   <= 1'b1;
               r_result <= w_result;
               r_inv    <= ~(r_itof | r_ftoi);
               r_ovf    <= (r_itof | r_ftoi) & r_sat;
            end
            default: ;
         endcase
      end
   end

   assign bus.result    = r_result;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.ovf       = r_ovf;
   assign bus.inv       = r_inv;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_fpu_cvt.sv
// ---------------------------------------------------------------------------
// tb_fpu_cvt : bench for fpu_cvt, default format (EW=8, MW=7, IW=16) plus a
// second instance with EW=5, MW=10, IW=32.
// ---------------------------------------------------------------------------
module tb_fpu_cvt;
   localparam logic [4:0] OP_FTOI = 5'h12;
   localparam logic [4:0] OP_ITOF = 5'h13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpu_cvt_if #(.DW(16)) bus ();
   fpu_cvt_if #(.DW(32)) bus2 ();

   fpu_cvt u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   fpu_cvt #(.EW(5), .MW(10), .IW(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [17:0] exp_q[$];    // {result, ovf, inv}
   logic [33:0] exp2_q[$];

   typedef struct {
      logic [4:0]  instr;
      logic [15:0] opd;
      logic [15:0] res;
      logic        ovf;
      logic        inv;
   } vec_t;
   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // scoreboards: compare each done against the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done got=%h", {bus.result, bus.ovf, bus.inv});
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            if ({bus.result, bus.ovf, bus.inv} !== e) begin
               errors++;
               $display("FAIL done_result got={res,ovf,inv}=%h exp=%h", {bus.result, bus.ovf, bus.inv}, e);
            end
         end
      end
      if (rst_n && bus2.done) begin
         checks++;
         if (exp2_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done2 got=%h", {bus2.result, bus2.ovf, bus2.inv});
         end else begin
            logic [33:0] e2;
            e2 = exp2_q.pop_front();
            if ({bus2.result, bus2.ovf, bus2.inv} !== e2) begin
               errors++;
               $display("FAIL done_result2 got={res,ovf,inv}=%h exp=%h", {bus2.result, bus2.ovf, bus2.inv}, e2);
            end
         end
      end
   end

   // drive one request for one cycle; called #1 after a rising edge
   task automatic issue(input logic [4:0] ins, input logic [15:0] opd, input logic [17:0] e, input bit push);
      bus.start = 1'b1; bus.instr = ins; bus.operand = opd;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic issue2(input logic [4:0] ins, input logic [31:0] opd, input logic [33:0] e);
      bus2.start = 1'b1; bus2.instr = ins; bus2.operand = opd;
      exp2_q.push_back(e);
      @(posedge clk); #1;
      bus2.start = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ftoi_ref(input logic s, input int e, input logic [6:0] m);
      real v;
      int  iv;
      v = 1.0 + real'(m) / 128.0;
      if (e >= 0) for (int k = 0; k < e; k++)  v = v * 2.0;
      else        for (int k = 0; k < -e; k++) v = v / 2.0;
      iv = $rtoi(v);
      if (s) iv = -iv;
      return iv[15:0];
   endfunction

   initial begin
      int cnt0;
      vecs[0]  = '{OP_ITOF, 16'd1784,  16'h44df, 1'b0, 1'b0};
      vecs[1]  = '{OP_FTOI, 16'hc4df,  16'hf908, 1'b0, 1'b0};
      vecs[2]  = '{OP_FTOI, 16'h3f00,  16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{OP_FTOI, 16'h4780,  16'h7fff, 1'b1, 1'b0};
      vecs[4]  = '{OP_FTOI, 16'hc700,  16'h8000, 1'b0, 1'b0};
      vecs[5]  = '{OP_ITOF, 16'h8000,  16'hc700, 1'b0, 1'b0};
      vecs[6]  = '{OP_ITOF, 16'h0000,  16'h0000, 1'b0, 1'b0};
`ifdef FPU_CVT_ROUND_NEAREST_EN
      vecs[7]  = '{OP_ITOF, 16'd259,   16'h4382, 1'b0, 1'b0};
      vecs[13] = '{OP_ITOF, 16'h7fff,  16'h4700, 1'b0, 1'b0};
`else
      vecs[7]  = '{OP_ITOF, 16'd259,   16'h4381, 1'b0, 1'b0};
      vecs[13] = '{OP_ITOF, 16'h7fff,  16'h46ff, 1'b0, 1'b0};
`endif
      vecs[8]  = '{OP_ITOF, 16'd257,   16'h4380, 1'b0, 1'b0};
      vecs[9]  = '{5'h11,   16'h1234,  16'h0000, 1'b0, 1'b1};
      vecs[10] = '{OP_FTOI, 16'hc780,  16'h8000, 1'b1, 1'b0};
      vecs[11] = '{OP_ITOF, 16'hf908,  16'hc4df, 1'b0, 1'b0};
      vecs[12] = '{OP_FTOI, 16'h8000,  16'h0000, 1'b0, 1'b0};
      vecs[14] = '{OP_FTOI, 16'h3f80,  16'h0001, 1'b0, 1'b0};
      vecs[15] = '{OP_FTOI, 16'h4700,  16'h7fff, 1'b1, 1'b0};
      vecs[16] = '{OP_FTOI, 16'hc6ff,  16'h8080, 1'b0, 1'b0};
      vecs[17] = '{OP_ITOF, 16'h0001,  16'h3f80, 1'b0, 1'b0};
      vecs[18] = '{5'h00,   16'h4780,  16'h0000, 1'b0, 1'b1};
      vecs[19] = '{OP_ITOF, 16'hffff,  16'hbf80, 1'b0, 1'b0};

      bus.start = 1'b0;  bus.instr = '0;  bus.operand = '0;
      bus2.start = 1'b0; bus2.instr = '0; bus2.operand = '0;

      // ---------- reset state ----------
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_result", 32'(bus.result), 32'h0);
      chk("rst_busy",   32'(bus.busy),   32'h0);
      chk("rst_done",   32'(bus.done),   32'h0);
      chk("rst_flags",  32'({bus.ovf, bus.inv}), 32'h0);
      chk("rst_state",  32'(bus.dbg_state), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ---------- latency / busy profile ----------
      issue(OP_ITOF, 16'd1784, {16'h44df, 2'b00}, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("lat_busy_c%0d", k), 32'(bus.busy), 32'(k < 3));
         chk($sformatf("lat_done_c%0d", k), 32'(bus.done), 32'(k == 3));
      end
      @(posedge clk); #1;

      // ---------- vector table ----------
      foreach (vecs[i]) begin
         issue(vecs[i].instr, vecs[i].opd, {vecs[i].res, vecs[i].ovf, vecs[i].inv}, 1'b1);
         settle();
         chk($sformatf("hold_v%0d", i), 32'({bus.result, bus.ovf, bus.inv}),
             32'({vecs[i].res, vecs[i].ovf, vecs[i].inv}));
      end

      // ---------- random FTOI against a real-valued model ----------
      for (int i = 0; i < 16; i++) begin
         logic       s;
         int         e;
         logic [6:0] m;
         s = 1'($urandom_range(0, 1));
         e = int'($urandom_range(0, 17)) - 3;
         m = 7'($urandom_range(0, 127));
         issue(OP_FTOI, {s, 8'(127 + e), m}, {ftoi_ref(s, e, m), 2'b00}, 1'b1);
         settle();
      end

      // ---------- start while busy is ignored; inputs not resampled ----------
      cnt0 = done_cnt;
      issue(OP_FTOI, 16'hc4df, {16'hf908, 2'b00}, 1'b1);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.instr = OP_ITOF; bus.operand = 16'h1234;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("busy_start_single_done", 32'(done_cnt - cnt0), 32'd1);

      // ---------- back-to-back start in the done cycle ----------
      cnt0 = done_cnt;
      issue(OP_ITOF, 16'd257, {16'h4380, 2'b00}, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_in_done_cycle", 32'(bus.done), 32'd1);
      issue(OP_FTOI, 16'h4780, {16'h7fff, 2'b10}, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_second_done", 32'(bus.done), 32'd1);
      @(posedge clk); #1;
      chk("b2b_done_count", 32'(done_cnt - cnt0), 32'd2);

      // ---------- reset in S2 ----------
      cnt0 = done_cnt;
      issue(OP_FTOI, 16'hc4df, 18'h0, 1'b0);
      @(posedge clk); #1;
      chk("mid_state_s2", 32'(bus.dbg_state), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_result", 32'(bus.result), 32'h0);
      chk("mid_rst_flags",  32'({bus.busy, bus.done, bus.ovf, bus.inv}), 32'h0);
      chk("mid_rst_state",  32'(bus.dbg_state), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("mid_rst_no_done", 32'(done_cnt - cnt0), 32'd0);
      chk("mid_rst_idle",    32'(bus.busy), 32'd0);

      // ---------- EW=5, MW=10, IW=32 instance ----------
      issue2(OP_ITOF, 32'd1784,      {32'h0000_66f8, 2'b00}); settle();
      issue2(OP_ITOF, 32'h7fff_ffff, {32'h0000_7fff, 2'b10}); settle();
      issue2(OP_FTOI, 32'h0000_66f8, {32'd1784,      2'b00}); settle();
      issue2(OP_ITOF, 32'hffff_ffff, {32'h0000_bc00, 2'b00}); settle();
      issue2(OP_FTOI, 32'h0000_7fff, {32'h0001_ffc0, 2'b00}); settle();

      repeat (2) @(posedge clk);
      chk("queue_drained",  32'(exp_q.size()),  32'd0);
      chk("queue2_drained", 32'(exp2_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
